// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a ready/valid handshake and a 2-entry skid buffer.
// Flush empties the stage and counts the discarded instructions in a saturating counter.
module if_id_skid_reg #(
   parameter int               PC_W      = 32,
   parameter int               INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int               CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pcregin,
   input  logic [INSTR_W-1:0] instructin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pcregout,
   output logic [INSTR_W-1:0] instructout,
   input  logic               flush,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   flush_drops
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on the other side's valid.

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   localparam int SW = CNT_W + 2;

   state_e               state_q, state_d;
   logic [PC_W-1:0]      main_pc_q, main_pc_d;
   logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
   logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic                 in_ready_q, in_ready_d;
   logic [CNT_W-1:0]     drops_q, drops_d;

   logic                 accept;
   logic                 consume;
   logic [SW-1:0]        drop_sum;

   assign out_valid   = (state_q != EMPTY);
   assign in_ready    = in_ready_q;
   assign pcregout    = main_pc_q;
   assign instructout = main_instr_q;
   assign occupancy   = state_q;
   assign flush_drops = drops_q;

   assign accept  = in_valid & in_ready_q;
   assign consume = out_valid & out_ready;

   // Held entries minus the one decode takes, plus the one fetch hands over.
   assign drop_sum = {2'b00, drops_q} + SW'(state_q) + SW'(accept) - SW'(consume);

   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      drops_d      = drops_q;

      if (flush) begin
         state_d      = EMPTY;
         main_pc_d    = '0;
         main_instr_d = NOP_INSTR;
         if (drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
            drops_d = {CNT_W{1'b1}};
         end else begin
            drops_d = drop_sum[CNT_W-1:0];
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d      = ONE;
                  main_pc_d    = pcregin;
                  main_instr_d = instructin;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_pc_d    = pcregin;
                  main_instr_d = instructin;
               end else if (accept) begin
                  state_d      = FULL;
                  skid_pc_d    = pcregin;
                  skid_instr_d = instructin;
               end else if (consume) begin
                  state_d      = EMPTY;
                  main_instr_d = NOP_INSTR;
               end
            end
            FULL: begin
               if (consume) begin
                  state_d      = ONE;
                  main_pc_d    = skid_pc_q;
                  main_instr_d = skid_instr_q;
               end
            end
            default: begin
               state_d      = EMPTY;
               main_pc_d    = '0;
               main_instr_d = NOP_INSTR;
            end
         endcase
      end

      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= EMPTY;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         in_ready_q   <= 1'b0;
         drops_q      <= '0;
      end else begin
         state_q      <= state_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         in_ready_q   <= in_ready_d;
         drops_q      <= drops_d;
      end
   end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: streaming, backpressure, flush cases,
// counter saturation (narrow-counter instance) and reset mid-operation.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        flush;
   logic [31:0] pcregin;
   logic [31:0] instructin;

   logic        in_ready, out_valid;
   logic [31:0] pcregout, instructout;
   logic [1:0]  occupancy;
   logic [7:0]  flush_drops;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_pcregout, s_instructout;
   logic [1:0]  s_occupancy;
   logic [1:0]  s_flush_drops;

   int n_total;
   int n_bad;

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pcregin(pcregin), .instructin(instructin), .out_valid(out_valid),
      .out_ready(out_ready), .pcregout(pcregout), .instructout(instructout),
      .flush(flush), .occupancy(occupancy), .flush_drops(flush_drops)
   );

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .pcregin(pcregin), .instructin(instructin), .out_valid(s_out_valid),
      .out_ready(out_ready), .pcregout(s_pcregout), .instructout(s_instructout),
      .flush(flush), .occupancy(s_occupancy), .flush_drops(s_flush_drops)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance one edge; outputs sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins);
      in_valid   = v;
      out_ready  = r;
      flush      = f;
      pcregin    = pc;
      instructin = ins;
   endtask

   task automatic check_out(input string tag, input logic ov, input logic ir,
                            input logic [31:0] pc, input logic [31:0] ins, input logic [1:0] occ);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
      check({tag, ".pcregout"}, 64'(pcregout), 64'(pc));
      check({tag, ".instructout"}, 64'(instructout), 64'(ins));
      check({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // reset held for two edges
      step();
      step();
      check_out("reset", 1'b0, 1'b0, 32'h0, NOP, 2'd0);
      check("reset.drops", 64'(flush_drops), 64'd0);

      rst = 1'b1;
      step();
      check_out("release", 1'b0, 1'b1, 32'h0, NOP, 2'd0);

      // streaming at one per cycle
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h12345678);
      step();
      check_out("stream0", 1'b1, 1'b1, 32'h10, 32'h12345678, 2'd1);
      drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h8C220004);
      step();
      check_out("stream1", 1'b1, 1'b1, 32'h14, 32'h8C220004, 2'd1);
      drive(1'b1, 1'b1, 1'b0, 32'h18, 32'h00432020);
      step();
      check_out("stream2", 1'b1, 1'b1, 32'h18, 32'h00432020, 2'd1);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
      check_out("drain", 1'b0, 1'b1, 32'h18, NOP, 2'd0);

      // backpressure fill into the skid entry
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h12345678);
      step();
      check_out("fill1", 1'b1, 1'b1, 32'h10, 32'h12345678, 2'd1);
      drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h87654321);
      step();
      check_out("fill2", 1'b1, 1'b0, 32'h10, 32'h12345678, 2'd2);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check_out("hold_full", 1'b1, 1'b0, 32'h10, 32'h12345678, 2'd2);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
      check_out("skid_out", 1'b1, 1'b1, 32'h20, 32'h87654321, 2'd1);
      step();
      check_out("bp_empty", 1'b0, 1'b1, 32'h20, NOP, 2'd0);

      // flush while full drops both entries
      drive(1'b1, 1'b0, 1'b0, 32'h30, 32'hAAAA0001);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'h34, 32'hAAAA0002);
      step();
      check("pre_flush.occ", 64'(occupancy), 64'd2);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      check_out("flush_full", 1'b0, 1'b1, 32'h0, NOP, 2'd0);
      check("flush_full.drops", 64'(flush_drops), 64'd2);

      // flush with concurrent accept and consume in ONE: only the accepted one counts
      drive(1'b1, 1'b0, 1'b0, 32'h40, 32'hBBBB0001);
      step();
      check_out("one_again", 1'b1, 1'b1, 32'h40, 32'hBBBB0001, 2'd1);
      drive(1'b1, 1'b1, 1'b1, 32'h44, 32'hBBBB0002);
      step();
      check_out("flush_acc_con", 1'b0, 1'b1, 32'h0, NOP, 2'd0);
      check("flush_acc_con.drops", 64'(flush_drops), 64'd3);
      check("flush_acc_con.sdrops", 64'(s_flush_drops), 64'd3);

      // reset wins over flush while full
      drive(1'b1, 1'b0, 1'b0, 32'h50, 32'hCCCC0001);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'h54, 32'hCCCC0002);
      step();
      check("pre_rst.occ", 64'(occupancy), 64'd2);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      rst = 1'b0;
      step();
      check_out("rst_mid", 1'b0, 1'b0, 32'h0, NOP, 2'd0);
      check("rst_mid.drops", 64'(flush_drops), 64'd0);
      check("rst_mid.sdrops", 64'(s_flush_drops), 64'd0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("rst_rel.in_ready", 64'(in_ready), 64'd1);

      // four flushes each discarding the accepted instruction
      for (int k = 0; k < 4; k++) begin
         logic [7:0] wide_exp [4];
         logic [1:0] sat_exp [4];
         wide_exp = '{8'd1, 8'd2, 8'd3, 8'd4};
         sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3};
         drive(1'b1, 1'b0, 1'b1, 32'h60 + 32'(k * 4), 32'hDDDD0000 + 32'(k));
         step();
         check($sformatf("sat%0d.sdrops", k), 64'(s_flush_drops), 64'(sat_exp[k]));
         check($sformatf("sat%0d.drops", k), 64'(flush_drops), 64'(wide_exp[k]));
         check($sformatf("sat%0d.out_valid", k), 64'(out_valid), 64'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("sat_idle.sdrops", 64'(s_flush_drops), 64'd3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
